// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between two bus masters and the arbiter.
// The master modport is the requester side; the slave modport is the arbiter side.
interface bus_arbiter_if;
  logic req_m1;
  logic req_m2;
  logic gnt_m1;
  logic gnt_m2;
  logic master_select;
  logic bus_busy;
  logic timeout_pulse;

  modport master (
    output req_m1, req_m2,
    input  gnt_m1, gnt_m2, master_select, bus_busy, timeout_pulse
  );

  modport slave (
    input  req_m1, req_m2,
    output gnt_m1, gnt_m2, master_select, bus_busy, timeout_pulse
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter: round-robin on ties, one-cycle turnaround between grants,
// and timed preemption of a long-running grant when the other master is waiting.
module bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic          clk,
  input logic          rst,
  bus_arbiter_if.slave bus
);
  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    GRANT_M1,
    GRANT_M2,
    HANDOVER
  } state_t;

  state_t        state;
  logic [CW-1:0] grant_cnt;
  logic          last_m2;
  logic          pick_m1;
  logic          pick_m2;

  // Arbitration decision used from IDLE and HANDOVER; on a tie the master
  // that was not served last wins.
  always_comb begin
    pick_m1 = bus.req_m1 && (!bus.req_m2 || last_m2);
    pick_m2 = bus.req_m2 && !pick_m1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      grant_cnt         <= '0;
      last_m2           <= 1'b1;
      bus.gnt_m1        <= 1'b0;
      bus.gnt_m2        <= 1'b0;
      bus.master_select <= 1'b0;
      bus.bus_busy      <= 1'b0;
      bus.timeout_pulse <= 1'b0;
    end else begin
      bus.timeout_pulse <= 1'b0;
      case (state)
        IDLE, HANDOVER: begin
          grant_cnt <= '0;
          if (pick_m1) begin
            state             <= GRANT_M1;
            last_m2           <= 1'b0;
            bus.gnt_m1        <= 1'b1;
            bus.gnt_m2        <= 1'b0;
            bus.master_select <= 1'b0;
            bus.bus_busy      <= 1'b1;
          end else if (pick_m2) begin
            state             <= GRANT_M2;
            last_m2           <= 1'b1;
            bus.gnt_m1        <= 1'b0;
            bus.gnt_m2        <= 1'b1;
            bus.master_select <= 1'b1;
            bus.bus_busy      <= 1'b1;
          end else begin
            state        <= IDLE;
            bus.gnt_m1   <= 1'b0;
            bus.gnt_m2   <= 1'b0;
            bus.bus_busy <= 1'b0;
          end
        end

        GRANT_M1: begin
          if (!bus.req_m1 || (grant_cnt == CNT_MAX && bus.req_m2)) begin
            state             <= HANDOVER;
            bus.gnt_m1        <= 1'b0;
            bus.bus_busy      <= 1'b0;
            bus.timeout_pulse <= bus.req_m1;
          end else if (grant_cnt != CNT_MAX) begin
            grant_cnt <= grant_cnt + CW'(1);
          end
        end

        GRANT_M2: begin
          // Still requesting at this point means the exit is a forced revoke.
          if (!bus.req_m2 || (grant_cnt == CNT_MAX && bus.req_m1)) begin
            state             <= HANDOVER;
            bus.gnt_m2        <= 1'b0;
            bus.bus_busy      <= 1'b0;
            bus.timeout_pulse <= bus.req_m2;
          end else if (grant_cnt != CNT_MAX) begin
            grant_cnt <= grant_cnt + CW'(1);
          end
        end

        default: begin
          state        <= IDLE;
          bus.gnt_m1   <= 1'b0;
          bus.gnt_m2   <= 1'b0;
          bus.bus_busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with TIMEOUT_CYCLES = 16; expected values are hand-computed.
module tb_bus_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  bus_arbiter_if bus ();

  bus_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int g1, input int g2,
                            input int sel, input int busy, input int pulse);
    check({tag, ".gnt_m1"}, int'(bus.gnt_m1), g1);
    check({tag, ".gnt_m2"}, int'(bus.gnt_m2), g2);
    check({tag, ".master_select"}, int'(bus.master_select), sel);
    check({tag, ".bus_busy"}, int'(bus.bus_busy), busy);
    check({tag, ".timeout_pulse"}, int'(bus.timeout_pulse), pulse);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Cycle-by-cycle invariants: mutual exclusion and bus_busy tracking the grants.
  always @(negedge clk) begin
    if (!rst) begin
      check("excl", int'(bus.gnt_m1 & bus.gnt_m2), 0);
      check("busy_or", int'(bus.bus_busy), int'(bus.gnt_m1 | bus.gnt_m2));
    end
  end

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    bus.req_m1 = 1'b0;
    bus.req_m2 = 1'b0;
    tick();
    tick();
    check_outs("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Single requester, then release.
    bus.req_m1 = 1'b1;
    tick();
    check_outs("m1_grant", 1, 0, 0, 1, 0);
    bus.req_m1 = 1'b0;
    tick();
    check_outs("m1_handover", 0, 0, 0, 0, 0);
    tick();
    check_outs("m1_idle", 0, 0, 0, 0, 0);

    // Request pulse that never straddles a rising edge is ignored.
    @(negedge clk);
    bus.req_m1 = 1'b1;
    #2 bus.req_m1 = 1'b0;
    tick();
    check_outs("withdrawn", 0, 0, 0, 0, 0);

    // Tie after reset goes to master1, then master2 after one turnaround cycle.
    do_reset();
    bus.req_m1 = 1'b1;
    bus.req_m2 = 1'b1;
    tick();
    check_outs("tie_m1", 1, 0, 0, 1, 0);
    bus.req_m1 = 1'b0;
    tick();
    check_outs("tie_handover", 0, 0, 0, 0, 0);
    tick();
    check_outs("tie_m2", 0, 1, 1, 1, 0);

    // Reset in the middle of a master2 grant.
    rst = 1'b1;
    tick();
    check_outs("rst_mid_grant", 0, 0, 0, 0, 0);
    rst = 1'b0;
    bus.req_m1 = 1'b1;
    tick();
    check_outs("post_rst_tie", 1, 0, 0, 1, 0);
    bus.req_m1 = 1'b0;
    bus.req_m2 = 1'b0;
    tick();
    tick();
    check_outs("post_rst_idle", 0, 0, 0, 0, 0);

    // Preemption of master2 after 16 grant cycles while master1 waits.
    do_reset();
    bus.req_m2 = 1'b1;
    tick();
    check_outs("to_cycle1", 0, 1, 1, 1, 0);
    for (int k = 2; k <= 16; k++) begin
      if (k == 4) bus.req_m1 = 1'b1;
      tick();
      check($sformatf("to_hold%0d", k), int'(bus.gnt_m2), 1);
      check($sformatf("to_nopulse%0d", k), int'(bus.timeout_pulse), 0);
    end
    tick();
    check_outs("to_revoke", 0, 0, 1, 0, 1);
    tick();
    check_outs("to_m1", 1, 0, 0, 1, 0);
    bus.req_m1 = 1'b0;
    bus.req_m2 = 1'b0;
    tick();
    check_outs("to_release", 0, 0, 0, 0, 0);

    // Lone requester keeps the bus past the timeout; a late competitor preempts at once.
    do_reset();
    bus.req_m1 = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      check($sformatf("long_gnt%0d", k), int'(bus.gnt_m1), 1);
      check($sformatf("long_nopulse%0d", k), int'(bus.timeout_pulse), 0);
    end
    bus.req_m2 = 1'b1;
    tick();
    check_outs("sat_revoke", 0, 0, 0, 0, 1);
    tick();
    check_outs("sat_m2", 0, 1, 1, 1, 0);
    bus.req_m1 = 1'b0;
    bus.req_m2 = 1'b0;
    tick();
    check_outs("sat_release", 0, 0, 1, 0, 0);
    tick();
    check_outs("sat_idle_sel", 0, 0, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
